// File: rtl/divrest_radix2_u.sv
// Unsigned restoring divider, one quotient bit per clock, start/busy handshake.
// Optional build macro DIVREST_SMALL_DIVIDEND_EN short-cuts divisions where a_in < b_in.
module divrest_radix2_u #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rstHigh,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             start_in,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out,
  output logic             busy
);

`ifdef DIVREST_SMALL_DIVIDEND_EN
  typedef enum logic [1:0] {IDLE, CALC, SKIP} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   qres_q, qres_d;
  logic [WIDTH-1:0]   rres_q, rres_d;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    qres_d  = qres_q;
    rres_d  = rres_q;
    // One extra bit on the trial subtraction keeps the borrow visible for any divisor.
    trial   = {rem_q, dvd_q[WIDTH-1]};
    diff    = trial - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (start_in) begin
          dvd_d   = a_in;
          dvs_d   = b_in;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = CALC;
`ifdef DIVREST_SMALL_DIVIDEND_EN
          if (a_in < b_in) state_d = SKIP;
`endif
        end
      end
      CALC: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          qres_d  = quo_d;
          rres_d  = rem_d;
          state_d = IDLE;
        end
      end
`ifdef DIVREST_SMALL_DIVIDEND_EN
      SKIP: begin
        // Dividend below divisor: quotient is zero and the dividend is the remainder.
        qres_d  = '0;
        rres_d  = dvd_q;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstHigh) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      qres_q  <= '0;
      rres_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      qres_q  <= qres_d;
      rres_q  <= rres_d;
    end
  end

  assign q_out = qres_q;
  assign r_out = rres_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_divrest_radix2_u.sv
// Scoreboard bench for divrest_radix2_u: directed vectors with hand-computed results.
module tb_divrest_radix2_u;

  logic        clk = 1'b0;
  logic        rstHigh;
  logic [31:0] a_in, b_in;
  logic        start_in;
  logic [31:0] q_out, r_out;
  logic        busy;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   abort_pending = 1'b0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[11] = '{
    '{32'd100,        32'd7,          32'd14,         32'd2},
    '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0},
    '{32'h80000000,   32'h80000000,   32'd1,          32'd0},
    '{32'h1234ABCD,   32'd0,          32'hFFFFFFFF,   32'h1234ABCD},
    '{32'd5,          32'd9,          32'd0,          32'd5},
    '{32'd0,          32'd3,          32'd0,          32'd0},
    '{32'd1000,       32'd10,         32'd100,        32'd0},
    '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0},
    '{32'd7,          32'hFFFFFFFF,   32'd0,          32'd7},
    '{32'h12345678,   32'h10,         32'h01234567,   32'd8},
    '{32'd200,        32'd200,        32'd1,          32'd0}
  };

  divrest_radix2_u #(.WIDTH(32)) dut (
    .clk      (clk),
    .rstHigh  (rstHigh),
    .a_in     (a_in),
    .b_in     (b_in),
    .start_in (start_in),
    .q_out    (q_out),
    .r_out    (r_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic int exp_cycles(input logic [31:0] a, input logic [31:0] b);
`ifdef DIVREST_SMALL_DIVIDEND_EN
    if (a < b) return 1;
`endif
    return 32;
  endfunction

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r);
    exp_t e;
    e.q   = q;
    e.r   = r;
    e.cyc = exp_cycles(a, b);
    sb.push_back(e);
  endtask

  // Caller sits just after a rising edge; returns at the same phase with busy low.
  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) return;
      @(posedge clk); #1;
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_idle: busy still %0b after 200 cycles, required 0", busy);
  endtask

  task automatic start_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] q, input logic [31:0] r);
    wait_idle();
    a_in     = a;
    b_in     = b;
    start_in = 1'b1;
    push_exp(a, b, q, r);
    @(posedge clk); #1;
    start_in = 1'b0;
    a_in     = $urandom;
    b_in     = $urandom;
  endtask

  task automatic check_idle_zero(input string name);
    n_vec++;
    if (busy !== 1'b0 || q_out !== 32'd0 || r_out !== 32'd0) begin
      n_err++;
      $display("FAIL %s: busy=%0b q=%h r=%h, required busy=0 q=0 r=0", name, busy, q_out, r_out);
    end
  endtask

  // Monitor: one scoreboard pop per busy falling edge, plus output stability while busy.
  initial begin : monitor
    logic        prev_busy = 1'b0;
    logic [31:0] prev_q = '0, prev_r = '0;
    int          cyc = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (busy) cyc++;
      if (prev_busy && busy) begin
        n_vec++;
        if (q_out !== prev_q || r_out !== prev_r) begin
          n_err++;
          $display("FAIL hold_during_calc: q=%h r=%h, required q=%h r=%h", q_out, r_out, prev_q, prev_r);
        end
      end
      if (prev_busy && !busy) begin
        if (abort_pending) begin
          abort_pending = 1'b0;
        end else if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: q=%h r=%h with empty scoreboard", q_out, r_out);
        end else begin
          e = sb.pop_front();
          n_vec++;
          if (q_out !== e.q || r_out !== e.r || cyc != e.cyc) begin
            n_err++;
            $display("FAIL div_result: q=%h r=%h busy_cycles=%0d, required q=%h r=%h busy_cycles=%0d",
                     q_out, r_out, cyc, e.q, e.r, e.cyc);
          end else begin
            $display("result q=%h r=%h after %0d busy cycles", q_out, r_out, cyc);
          end
        end
        cyc = 0;
      end
      prev_busy = busy;
      prev_q    = q_out;
      prev_r    = r_out;
    end
  end

  initial begin : stimulus
    rstHigh  = 1'b1;
    start_in = 1'b0;
    a_in     = '0;
    b_in     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset_state");
    rstHigh = 1'b0;
    @(posedge clk); #1;

    // Start ignored while reset is high.
    rstHigh  = 1'b1;
    start_in = 1'b1;
    a_in     = 32'd50;
    b_in     = 32'd5;
    @(posedge clk); #1;
    rstHigh  = 1'b0;
    start_in = 1'b0;
    check_idle_zero("reset_overrides_start");

    foreach (vecs[i]) begin
      start_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
      $display("issue a=%h b=%h", vecs[i].a, vecs[i].b);
    end

    // start held high with changed operands through CALC; second starts as busy falls.
    wait_idle();
    a_in     = 32'd100000;
    b_in     = 32'd3;
    start_in = 1'b1;
    push_exp(32'd100000, 32'd3, 32'd33333, 32'd1);
    @(posedge clk); #1;
    a_in = 32'd50;
    b_in = 32'd6;
    push_exp(32'd50, 32'd6, 32'd8, 32'd2);
    $display("issue a=%h b=%h with start held for a=%h b=%h", 32'd100000, 32'd3, 32'd50, 32'd6);
    wait_idle();
    @(posedge clk); #1;
    start_in = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL back_to_back_accept: busy=%0b, required 1", busy);
    end

    // Abort in the middle of a division.
    start_div(32'hDEADBEEF, 32'd13, 32'd0, 32'd0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    void'(sb.pop_back());
    abort_pending = 1'b1;
    rstHigh       = 1'b1;
    @(posedge clk); #1;
    rstHigh = 1'b0;
    check_idle_zero("abort_reset");
    $display("abort mid-division, outputs cleared");

    start_div(32'd9, 32'd4, 32'd2, 32'd1);
    $display("issue a=%h b=%h", 32'd9, 32'd4);

    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
